// File: rtl/move_controller_if.sv
// Handshake bundle between the move controller, the button debouncer and the node grid wrapper.
interface move_controller_if #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned CELLS   = 16,
  parameter int unsigned VALUE_W = 4
);
  localparam int unsigned AW = $clog2(CELLS);

  logic [3:0]         btn_dir;
  logic               btn_valid;
  logic [N_LANES-1:0] lane_done;
  logic               moved;
  logic [CELLS-1:0]   empty_mask;
  logic [7:0]         rand_val;

  logic [3:0]         start_dir;
  logic               spawn_preset;
  logic [AW-1:0]      spawn_addr;
  logic [VALUE_W-1:0] spawn_value;
  logic               busy;
  logic               move_done;
  logic               no_move;
  logic               timeout_err;

  modport master (
    input  btn_dir, btn_valid, lane_done, moved, empty_mask, rand_val,
    output start_dir, spawn_preset, spawn_addr, spawn_value,
           busy, move_done, no_move, timeout_err
  );

  modport slave (
    output btn_dir, btn_valid, lane_done, moved, empty_mask, rand_val,
    input  start_dir, spawn_preset, spawn_addr, spawn_value,
           busy, move_done, no_move, timeout_err
  );
endinterface

// File: rtl/move_controller.sv
// Initiator of the grid ready/preset protocol: issues one move, waits for every lane,
// then presets one empty cell with a new tile.
module move_controller #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned CELLS   = 16,
  parameter int unsigned VALUE_W = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  move_controller_if.master bus
);
  localparam int unsigned AW = $clog2(CELLS);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SPAWN, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         dir_q, dir_d;
  logic [N_LANES-1:0] done_acc_q, done_acc_d;
  logic               moved_acc_q, moved_acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [3:0]         start_dir_q, start_dir_d;
  logic               spawn_preset_q, spawn_preset_d;
  logic [AW-1:0]      spawn_addr_q, spawn_addr_d;
  logic [VALUE_W-1:0] spawn_value_q, spawn_value_d;
  logic               busy_q, busy_d;
  logic               move_done_q, move_done_d;
  logic               no_move_q, no_move_d;
  logic               timeout_err_q, timeout_err_d;

  logic [N_LANES-1:0] done_now;
  logic               moved_now;
  logic [CW-1:0]      cnt_inc;
  logic [AW-1:0]      scan_start;
  logic [AW-1:0]      scan_pos;
  logic [AW-1:0]      scan_idx;
  logic               scan_found;
  logic               unused_rand;

  assign unused_rand = ^bus.rand_val;
  assign scan_start  = AW'(bus.rand_val);

  // First empty cell at or after scan_start, wrapping around the grid.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_pos   = '0;
    for (int i = 0; i < int'(CELLS); i++) begin
      scan_pos = AW'((32'(scan_start) + 32'(i)) % 32'(CELLS));
      if (!scan_found && bus.empty_mask[scan_pos]) begin
        scan_found = 1'b1;
        scan_idx   = scan_pos;
      end
    end
  end

  assign done_now  = done_acc_q | bus.lane_done;
  assign moved_now = moved_acc_q | bus.moved;
  assign cnt_inc   = cnt_q + CW'(1);

  // Next state plus the values every output register takes on the following cycle.
  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    done_acc_d     = done_acc_q;
    moved_acc_d    = moved_acc_q;
    cnt_d          = cnt_q;
    spawn_preset_d = 1'b0;
    spawn_addr_d   = '0;
    spawn_value_d  = '0;
    move_done_d    = 1'b0;
    no_move_d      = 1'b0;
    timeout_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.btn_valid && $onehot(bus.btn_dir)) begin
          dir_d   = bus.btn_dir;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        done_acc_d  = '0;
        moved_acc_d = 1'b0;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        done_acc_d  = done_now;
        moved_acc_d = moved_now;
        cnt_d       = cnt_inc;
        if (&done_now) begin
          if (moved_now) begin
            // Spawn target is fixed on the completing cycle so it is registered into SPAWN.
            state_d = SPAWN;
            if (scan_found) begin
              spawn_preset_d = 1'b1;
              spawn_addr_d   = scan_idx;
              spawn_value_d  = (bus.rand_val[7:5] == 3'b000) ? VALUE_W'(2) : VALUE_W'(1);
            end
          end else begin
            no_move_d   = 1'b1;
            move_done_d = 1'b1;
            state_d     = DONE;
          end
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          move_done_d   = 1'b1;
          state_d       = DONE;
        end
      end
      SPAWN: begin
        move_done_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    start_dir_d = (state_d == ISSUE) ? dir_d : 4'b0000;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      dir_q          <= '0;
      done_acc_q     <= '0;
      moved_acc_q    <= 1'b0;
      cnt_q          <= '0;
      start_dir_q    <= '0;
      spawn_preset_q <= 1'b0;
      spawn_addr_q   <= '0;
      spawn_value_q  <= '0;
      busy_q         <= 1'b0;
      move_done_q    <= 1'b0;
      no_move_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      done_acc_q     <= done_acc_d;
      moved_acc_q    <= moved_acc_d;
      cnt_q          <= cnt_d;
      start_dir_q    <= start_dir_d;
      spawn_preset_q <= spawn_preset_d;
      spawn_addr_q   <= spawn_addr_d;
      spawn_value_q  <= spawn_value_d;
      busy_q         <= busy_d;
      move_done_q    <= move_done_d;
      no_move_q      <= no_move_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.start_dir    = start_dir_q;
  assign bus.spawn_preset = spawn_preset_q;
  assign bus.spawn_addr   = spawn_addr_q;
  assign bus.spawn_value  = spawn_value_q;
  assign bus.busy         = busy_q;
  assign bus.move_done    = move_done_q;
  assign bus.no_move      = no_move_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule
